muldiv_seq: RTL and testbench

//  Iterative sequencer for RV64M multiply/divide (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 62 ++++++
 rtl/muldiv_seq.sv | 139 +++++++++++++
 tb/tb_muldiv_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared types and constants for the RV64M multiply/divide sequencer
package muldiv_seq_pkg;

    typedef enum logic [3:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } muldiv_op_t;

    localparam logic [6:0] F7_muldiv  = 7'b0000001;
    localparam logic [6:0] OPCODE_R   = 7'b0110011;
    localparam logic [6:0] OPCODE_R_W = 7'b0111011;

    typedef struct packed {
        logic       isMulDiv;
        logic       is_word;
        muldiv_op_t muldiv_op;
    } control_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    // Which slice of the datapath becomes the result
    typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO} res_sel_t;

    function automatic logic op_is_div(input muldiv_op_t o);
        return o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add / restoring shift-subtract datapath
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   load_sh,
    input  logic [XLEN-1:0]   load_opnd,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0]   sh_nxt
);

    // acc: product (mul) or partial remainder (div); sh: multiplier/dividend, MSB first,
    // with quotient bits shifted in at the bottom; opnd: multiplicand or divisor.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   sh_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;

    assign shifted = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
    assign trial   = shifted - {1'b0, opnd_q};

    // Next-state of the datapath; exposed so the FSM can capture the final step's result
    always_comb begin
        acc_nxt = acc_q;
        sh_nxt  = sh_q;
        if (load) begin
            acc_nxt = '0;
            sh_nxt  = load_sh;
        end else if (step) begin
            if (is_div) begin
                // Remainder stays below the divisor, so the top half is always zero
                acc_nxt = {{XLEN{1'b0}}, trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0]};
                sh_nxt  = {sh_q[XLEN-2:0], ~trial[XLEN]};
            end else begin
                acc_nxt = {acc_q[2*XLEN-2:0], 1'b0}
                        + {{XLEN{1'b0}}, (sh_q[XLEN-1] ? opnd_q : {XLEN{1'b0}})};
                sh_nxt  = {sh_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
        end else begin
            acc_q <= acc_nxt;
            sh_q  <= sh_nxt;
            if (load) begin
                opnd_q <= load_opnd;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV64M multiply/divide sequencer for the EX stage
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    localparam int H = XLEN / 2;
    localparam logic [XLEN-1:0] MIN_F = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(H+1){1'b1}}, {(H-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, div_q, word_q;
    res_sel_t          sel_q;

    muldiv_op_t        op_eff;
    logic              accept, step, is_div, is_rem, sgn_a, sgn_b, sa, sb;
    logic              div_zero, ovf, special;
    logic [XLEN-1:0]   a_ext, b_ext, a_sx, b_sx, ma, mb, special_val;
    logic [H-1:0]      a_neg_h, b_neg_h;
    logic [2*XLEN-1:0] acc_nxt, base, prod;
    logic [XLEN-1:0]   sh_nxt, res, fin;

    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign step      = (state_q == ST_BUSY) && !flush;

    // Operand decode: signedness, magnitudes and the cases resolved without iterating
    always_comb begin
        op_eff   = (op > MD_REMU) ? MD_MUL : op;
        is_div   = op_is_div(op_eff);
        is_rem   = op_eff inside {MD_REM, MD_REMU};
        sgn_a    = op_eff inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        sgn_b    = op_eff inside {MD_MULH, MD_DIV, MD_REM};
        a_ext    = is_word ? {{H{1'b0}}, a[H-1:0]} : a;
        b_ext    = is_word ? {{H{1'b0}}, b[H-1:0]} : b;
        a_sx     = is_word ? {{H{a[H-1]}}, a[H-1:0]} : a;
        b_sx     = is_word ? {{H{b[H-1]}}, b[H-1:0]} : b;
        sa       = sgn_a && (is_word ? a[H-1] : a[XLEN-1]);
        sb       = sgn_b && (is_word ? b[H-1] : b[XLEN-1]);
        a_neg_h  = ~a[H-1:0] + 1'b1;
        b_neg_h  = ~b[H-1:0] + 1'b1;
        ma       = sa ? (is_word ? {{H{1'b0}}, a_neg_h} : (~a + 1'b1)) : a_ext;
        mb       = sb ? (is_word ? {{H{1'b0}}, b_neg_h} : (~b + 1'b1)) : b_ext;
        div_zero = is_div && (b_ext == '0);
        ovf      = is_div && sgn_a && (a_sx == (is_word ? MIN_W : MIN_F)) && (b_sx == '1);
        special  = div_zero || ovf;
        if (div_zero) begin
            special_val = is_rem ? a_sx : '1;
        end else begin
            special_val = is_rem ? '0 : (is_word ? MIN_W : MIN_F);
        end
    end

    // Final sign correction and slice selection on the last step's datapath value
    always_comb begin
        base = (sel_q == SEL_QUO) ? {{XLEN{1'b0}}, sh_nxt} : acc_nxt;
        prod = neg_q ? (~base + 1'b1) : base;
        res  = (sel_q == SEL_HI) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        fin  = word_q ? {{H{res[H-1]}}, res[H-1:0]} : res;
    end

    // Next-state logic; flush overrides every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // State, iteration counter, per-op controls and the held result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            div_q    <= 1'b0;
            word_q   <= 1'b0;
            sel_q    <= SEL_LO;
            out_data <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= CNT_W'(is_word ? H - 1 : XLEN - 1);
                neg_q  <= is_rem ? sa : (sa ^ sb);
                div_q  <= is_div;
                word_q <= is_word;
                if (is_div) begin
                    sel_q <= is_rem ? SEL_LO : SEL_QUO;
                end else begin
                    sel_q <= (op_eff == MD_MUL || is_word) ? SEL_LO : SEL_HI;
                end
                if (special) begin
                    out_data <= special_val;
                end
            end else if (step) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_data <= fin;
                end
            end
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && !special),
        .step      (step),
        .is_div    (div_q),
        .load_sh   (is_div ? (is_word ? (ma << H) : ma) : (is_word ? (mb << H) : mb)),
        .load_opnd (is_div ? mb : ma),
        .acc_nxt   (acc_nxt),
        .sh_nxt    (sh_nxt)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    muldiv_op_t  op = MD_MUL;
    logic        is_word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_word(is_word), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_md(input muldiv_op_t o, input logic w,
                                           input logic [63:0] x, input logic [63:0] y);
        logic [127:0] ea, eb, pr;
        logic [31:0]  x32, y32, q32, r32;
        logic [63:0]  q64, r64;
        logic         sx, sy, sgn;
        sx  = o inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        sy  = o inside {MD_MULH, MD_DIV, MD_REM};
        sgn = o inside {MD_DIV, MD_REM};
        x32 = x[31:0];
        y32 = y[31:0];
        if (o == MD_MUL) begin
            if (w) begin
                r32 = x32 * y32;
                return {{32{r32[31]}}, r32};
            end
            return x * y;
        end
        if (o inside {MD_MULH, MD_MULHSU, MD_MULHU}) begin
            ea = sx ? {{64{x[63]}}, x} : {64'b0, x};
            eb = sy ? {{64{y[63]}}, y} : {64'b0, y};
            pr = ea * eb;
            return pr[127:64];
        end
        if (w) begin
            if (y32 == 0) begin
                q32 = '1; r32 = x32;
            end else if (sgn && x32 == 32'h8000_0000 && y32 == '1) begin
                q32 = x32; r32 = '0;
            end else if (sgn) begin
                q32 = $signed(x32) / $signed(y32); r32 = $signed(x32) % $signed(y32);
            end else begin
                q32 = x32 / y32; r32 = x32 % y32;
            end
            if (o inside {MD_REM, MD_REMU}) return {{32{r32[31]}}, r32};
            return {{32{q32[31]}}, q32};
        end
        if (y == 0) begin
            q64 = '1; r64 = x;
        end else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin
            q64 = x; r64 = '0;
        end else if (sgn) begin
            q64 = $signed(x) / $signed(y); r64 = $signed(x) % $signed(y);
        end else begin
            q64 = x / y; r64 = x % y;
        end
        return (o inside {MD_REM, MD_REMU}) ? r64 : q64;
    endfunction

    function automatic int exp_lat(input muldiv_op_t o, input logic w,
                                   input logic [63:0] x, input logic [63:0] y);
        logic sgn;
        sgn = o inside {MD_DIV, MD_REM};
        if (!(o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU})) return w ? 32 : 64;
        if (w) begin
            if (y[31:0] == 0 || (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == '1)) return 0;
            return 32;
        end
        if (y == 0 || (sgn && x == 64'h8000_0000_0000_0000 && y == '1)) return 0;
        return 64;
    endfunction

    // Issues one op with out_ready high; returns the result and cycles from accept edge to out_valid
    task automatic run_op(input muldiv_op_t o, input logic w, input logic [63:0] x,
                          input logic [63:0] y, output logic [63:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        op = o; is_word = w; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = out_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready/out_valid/busy=%b out_data=%h, want 100 / 0",
                     {in_ready, out_valid, busy}, out_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [63:0] r;
        int l;
        muldiv_op_t  ops[8] = '{MD_MUL, MD_MULHU, MD_MULH, MD_DIV, MD_REM, MD_DIV, MD_DIVU, MD_REM};
        logic        ws[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] xs[8]  = '{64'd7, '1, '1, -64'sd7, -64'sd7, 64'h1_8000_0000, 64'd12345,
                                64'h0_8000_0005};
        logic [63:0] ys[8]  = '{-64'sd3, '1, '1, 64'd2, 64'd2, '1, 64'd0, 64'd0};
        logic [63:0] es[8]  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
                                -64'sd3, -64'sd1, 64'hFFFF_FFFF_8000_0000, '1,
                                64'hFFFF_FFFF_8000_0005};
        int          ls[8]  = '{64, 64, 64, 64, 64, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            // ops[7] is REMW: REM with is_word
            run_op(ops[i], ws[i], xs[i], ys[i], r, l);
            vectors++;
            if (r !== es[i]) begin
                miscompares++;
                $display("FAIL directed_%0d result: got %h want %h", i, r, es[i]);
            end
            vectors++;
            if (l !== ls[i]) begin
                miscompares++;
                $display("FAIL directed_%0d latency: got %0d want %0d", i, l, ls[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] r, x, y, e;
        int l, el;
        logic w;
        muldiv_op_t o;
        muldiv_op_t wops[5] = '{MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        for (int i = 0; i < 48; i++) begin
            w = $urandom_range(0, 2) == 0;
            o = w ? wops[$urandom_range(0, 4)] : muldiv_op_t'($urandom_range(0, 7));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000; y = '1; end
                2: y = {56'd0, 8'($urandom)};
                3: x = -x;
                default: ;
            endcase
            e  = ref_md(o, w, x, y);
            el = exp_lat(o, w, x, y);
            run_op(o, w, x, y, r, l);
            vectors++;
            if (r !== e) begin
                miscompares++;
                $display("FAIL random_%0d op=%0d w=%b a=%h b=%h: got %h want %h",
                         i, o, w, x, y, r, e);
            end
            vectors++;
            if (l !== el) begin
                miscompares++;
                $display("FAIL random_%0d latency: got %0d want %0d", i, l, el);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] r;
        int l;
        for (int i = 0; i < 3; i++) begin
            run_op(MD_DIVU, 1'b0, 64'd100 + 64'(i), 64'd0, r, l);
            vectors++;
            if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
                miscompares++;
                $display("FAIL b2b_%0d handshake: in_ready=%b out_valid=%b want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_flush;
        logic [63:0] r;
        int l;
        int seen;
        op = MD_DIV; is_word = 1'b0; a = 64'd1000; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        vectors++;
        if (!(busy === 1'b1 && in_ready === 1'b0)) begin
            miscompares++;
            $display("FAIL flush_pre: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        vectors++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL flush_idle: busy/in_ready/out_valid=%b want 010",
                     {busy, in_ready, out_valid});
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL flush_stale: out_valid high %0d cycles, want 0", seen);
        end
        run_op(MD_MUL, 1'b0, 64'd2, 64'd3, r, l);
        vectors++;
        if (r !== 64'd6) begin
            miscompares++;
            $display("FAIL flush_after_mul: got %h want 6", r);
        end
    endtask

    task automatic test_hold;
        logic [63:0] x, y, e, d;
        int l;
        x = {$urandom, $urandom};
        y = {32'd0, $urandom};
        e = ref_md(MD_REMU, 1'b0, x, y);
        op = MD_REMU; is_word = 1'b0; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = '1; b = '1;
        l = 0;
        while (!out_valid && l < 200) begin
            @(posedge clk); #1; l++;
        end
        d = out_data;
        vectors++;
        if (d !== e) begin
            miscompares++;
            $display("FAIL hold_result: got %h want %h", d, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_data === e)) begin
                miscompares++;
                $display("FAIL hold_cycle_%0d: out_valid=%b in_ready=%b data=%h want 1 0 %h",
                         i, out_valid, in_ready, out_data, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin
            miscompares++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        op = MD_MULHU; is_word = 1'b0; a = '1; b = '1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid: in_ready/out_valid/busy=%b out_data=%h want 100 / 0",
                     {in_ready, out_valid, busy}, out_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_flush;
        test_hold;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
